alex_relay_spi: RTL and testbench

Serialises the Alex filter/relay selection onto the Alex board's SPI shift-register chain. Sits directly downstream of the LPF selector: takes its one-hot 7-bit LPF code plus attenuator, antenna and PTT controls, waits for the selection to settle, then shifts a 16-bit relay word out MSB first and pulses the latch strobe. Runs in the Mercury FPGA clock domain; all outputs are registered.

---
 rtl/alex_relay_spi.sv | 164 ++++++++++++++++
 tb/tb_alex_relay_spi.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/alex_relay_spi.sv
// Serialises the Alex relay word (PTT, antenna, attenuator, LPF) onto the Alex SPI chain.
// Non-PTT changes must settle first; PTT changes and the post-reset reload shift out at once.
module alex_relay_spi #(
  parameter int CLK_DIV = 4,
  parameter int SETTLE  = 1024
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [6:0] LPF,
  input  logic [1:0] atten,
  input  logic [1:0] ant,
  input  logic       ptt,
  output logic       SPI_data,
  output logic       SPI_clock,
  output logic       SPI_strobe,
  output logic       busy
);

  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE - 1);
  localparam logic [7:0]  DIV_LAST    = 8'(CLK_DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_SHIFT, S_STROBE} state_t;

  state_t      r_state;
  logic [15:0] r_curWord;
  logic [15:0] r_prevWord;
  logic [15:0] r_loadedWord;
  logic [15:0] r_shiftReg;
  logic [15:0] r_settleCnt;
  logic [7:0]  r_divCnt;
  logic [3:0]  r_bitCnt;
  logic        r_half;
  logic        r_pending;
  logic        r_primed;
  logic        r_spiData;
  logic        r_spiClock;
  logic        r_spiStrobe;
  logic        r_busy;

  logic        w_pttChange;
  logic        w_backToLoaded;
  logic        w_divDone;
  logic        w_startShift;

  assign w_pttChange    = r_curWord[15] ^ r_loadedWord[15];
  assign w_backToLoaded = (r_curWord == r_loadedWord) && !r_pending;
  assign w_divDone      = (r_divCnt == DIV_LAST);

  // r_primed holds off the reset reload until r_curWord carries a real sample.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_curWord  <= '0;
      r_prevWord <= '0;
      r_primed   <= 1'b0;
    end else begin
      r_curWord  <= {ptt, ant, atten, 4'b0000, LPF};
      r_prevWord <= r_curWord;
      r_primed   <= 1'b1;
    end
  end

  always_comb begin
    w_startShift = 1'b0;
    case (r_state)
      S_IDLE:   w_startShift = (r_pending && r_primed) || w_pttChange;
      S_SETTLE: w_startShift = w_pttChange ||
                               (!w_backToLoaded && (r_curWord == r_prevWord) &&
                                (r_settleCnt == SETTLE_LAST));
      default:  w_startShift = 1'b0;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_loadedWord <= '0;
      r_shiftReg   <= '0;
      r_settleCnt  <= '0;
      r_divCnt     <= '0;
      r_bitCnt     <= '0;
      r_half       <= 1'b0;
      r_pending    <= 1'b1;
      r_spiData    <= 1'b0;
      r_spiClock   <= 1'b0;
      r_spiStrobe  <= 1'b0;
      r_busy       <= 1'b0;
    end else if (w_startShift) begin
      r_state      <= S_SHIFT;
      r_shiftReg   <= r_curWord;
      r_loadedWord <= r_curWord;
      r_pending    <= 1'b0;
      r_bitCnt     <= 4'd15;
      r_divCnt     <= '0;
      r_half       <= 1'b0;
      r_spiData    <= r_curWord[15];
      r_spiClock   <= 1'b0;
      r_busy       <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_curWord != r_loadedWord) begin
            r_state     <= S_SETTLE;
            r_settleCnt <= '0;
            r_busy      <= 1'b1;
          end
        end
        S_SETTLE: begin
          if (w_backToLoaded) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else if (r_curWord != r_prevWord) begin
            r_settleCnt <= '0;
          end else begin
            r_settleCnt <= r_settleCnt + 16'd1;
          end
        end
        // Data changes only on the falling SPI edge, so it is stable around each rise.
        S_SHIFT: begin
          if (!w_divDone) begin
            r_divCnt <= r_divCnt + 8'd1;
          end else begin
            r_divCnt <= '0;
            if (!r_half) begin
              r_half     <= 1'b1;
              r_spiClock <= 1'b1;
            end else begin
              r_half     <= 1'b0;
              r_spiClock <= 1'b0;
              r_shiftReg <= {r_shiftReg[14:0], 1'b0};
              if (r_bitCnt == 4'd0) begin
                r_state     <= S_STROBE;
                r_spiData   <= 1'b0;
                r_spiStrobe <= 1'b1;
              end else begin
                r_bitCnt  <= r_bitCnt - 4'd1;
                r_spiData <= r_shiftReg[14];
              end
            end
          end
        end
        S_STROBE: begin
          if (!w_divDone) begin
            r_divCnt <= r_divCnt + 8'd1;
          end else begin
            r_divCnt    <= '0;
            r_spiStrobe <= 1'b0;
            r_state     <= S_IDLE;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign SPI_data   = r_spiData;
  assign SPI_clock  = r_spiClock;
  assign SPI_strobe = r_spiStrobe;
  assign busy       = r_busy;

endmodule

// File: tb/tb_alex_relay_spi.sv
// Directed bench for alex_relay_spi (CLK_DIV=4, SETTLE=16): a negedge monitor
// rebuilds each shifted word and its timing, and the stimulus compares against hand-computed values.
module tb_alex_relay_spi;

  logic       clock;
  logic       reset;
  logic [6:0] LPF;
  logic [1:0] atten;
  logic [1:0] ant;
  logic       ptt;
  logic       SPI_data;
  logic       SPI_clock;
  logic       SPI_strobe;
  logic       busy;

  int checks = 0;
  int bad = 0;
  int cycle = 0;
  int chgCycle = 0;

  int          edgeCnt = 0;
  int          strobeCnt = 0;
  logic [15:0] capWord = '0;
  logic [15:0] lastWord = '0;
  int          lastEdges = 0;
  int          lastStrobe = 0;
  int          xferEnd = 0;
  int          xferCount = 0;
  int          busyRise = 0;
  logic        prevSclk = 1'b0;
  logic        prevStrobe = 1'b0;
  logic        prevBusy = 1'b0;

  alex_relay_spi #(.CLK_DIV(4), .SETTLE(16)) dut (
    .clock(clock), .reset(reset), .LPF(LPF), .atten(atten), .ant(ant), .ptt(ptt),
    .SPI_data(SPI_data), .SPI_clock(SPI_clock), .SPI_strobe(SPI_strobe), .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cycle <= cycle + 1;

  // Transfers are recorded when the strobe falls, which coincides with the return to IDLE.
  always @(negedge clock) begin
    if (reset) begin
      edgeCnt   = 0;
      strobeCnt = 0;
    end else begin
      if (SPI_clock && !prevSclk) begin
        capWord = {capWord[14:0], SPI_data};
        edgeCnt++;
      end
      if (SPI_strobe) strobeCnt++;
      if (!SPI_strobe && prevStrobe) begin
        lastWord   = capWord;
        lastEdges  = edgeCnt;
        lastStrobe = strobeCnt;
        xferEnd    = cycle;
        xferCount++;
        edgeCnt    = 0;
        strobeCnt  = 0;
      end
      if (busy && !prevBusy) busyRise = cycle;
    end
    prevSclk   = SPI_clock;
    prevStrobe = SPI_strobe;
    prevBusy   = busy;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [6:0] lpf, input logic [1:0] att,
                               input logic [1:0] an, input logic p);
    @(negedge clock);
    LPF      = lpf;
    atten    = att;
    ant      = an;
    ptt      = p;
    chgCycle = cycle;
  endtask

  task automatic waitTransfer(input int target, input int budget);
    int n = 0;
    while (xferCount < target && n < budget) begin
      @(posedge clock);
      n++;
    end
    checkOutput("xfer_wait", xferCount, target);
  endtask

  int relCycle;
  int c1;
  int e1;
  int xc;

  initial begin
    reset = 1'b1;
    LPF   = 7'b0001000;
    atten = 2'b00;
    ant   = 2'b00;
    ptt   = 1'b0;
    repeat (3) @(negedge clock);
    checkOutput("reset_outputs", {28'd0, SPI_data, SPI_clock, SPI_strobe, busy}, 32'd0);

    // 1: reset release reload of 160m word
    reset    = 1'b0;
    relCycle = cycle;
    waitTransfer(1, 300);
    checkOutput("t1_start", busyRise - relCycle, 2);
    checkOutput("t1_word", lastWord, 16'h0008);
    checkOutput("t1_edges", lastEdges, 16);
    checkOutput("t1_strobe", lastStrobe, 4);
    checkOutput("t1_length", xferEnd - busyRise, 132);
    repeat (100) @(negedge clock);
    checkOutput("t1_quiet_count", xferCount, 1);
    checkOutput("t1_quiet_busy", {31'd0, busy}, 0);

    // 2: settled LPF changes
    applyStimulus(7'b0000001, 2'b00, 2'b00, 1'b0);
    waitTransfer(2, 400);
    checkOutput("t2a_word", lastWord, 16'h0001);
    applyStimulus(7'b1000000, 2'b00, 2'b00, 1'b0);
    c1 = chgCycle;
    waitTransfer(3, 400);
    checkOutput("t2_busy_settle", busyRise - c1, 2);
    checkOutput("t2_end", xferEnd - c1, 150);
    checkOutput("t2_word", lastWord, 16'h0040);
    checkOutput("t2_edges", lastEdges, 16);

    // 3: toggling restarts settling; only the final value goes out
    xc = xferCount;
    applyStimulus(7'b0000100, 2'b00, 2'b00, 1'b0);
    repeat (10) @(negedge clock);
    applyStimulus(7'b0000010, 2'b00, 2'b00, 1'b0);
    repeat (10) @(negedge clock);
    applyStimulus(7'b0001000, 2'b00, 2'b00, 1'b0);
    repeat (10) @(negedge clock);
    applyStimulus(7'b0100000, 2'b00, 2'b00, 1'b0);
    repeat (10) @(negedge clock);
    checkOutput("t3_quiet", xferCount, xc);
    applyStimulus(7'b0010000, 2'b11, 2'b00, 1'b0);
    c1 = chgCycle;
    waitTransfer(xc + 1, 400);
    checkOutput("t3_end", xferEnd - c1, 150);
    checkOutput("t3_word", lastWord, 16'h1810);
    repeat (200) @(negedge clock);
    checkOutput("t3_single", xferCount, xc + 1);

    // 4: PTT bypasses settling, and a PTT raised mid-transfer goes out next
    applyStimulus(7'b0000010, 2'b00, 2'b00, 1'b1);
    c1 = chgCycle;
    waitTransfer(xc + 2, 300);
    checkOutput("t4_start", busyRise - c1, 2);
    checkOutput("t4_end", xferEnd - c1, 134);
    checkOutput("t4_word", lastWord, 16'h8002);
    applyStimulus(7'b0000010, 2'b00, 2'b00, 1'b0);
    repeat (20) @(negedge clock);
    applyStimulus(7'b0000010, 2'b00, 2'b00, 1'b1);
    waitTransfer(xc + 3, 300);
    checkOutput("t4b_word", lastWord, 16'h0002);
    e1 = xferEnd;
    waitTransfer(xc + 4, 300);
    checkOutput("t4c_word", lastWord, 16'h8002);
    checkOutput("t4c_gap", xferEnd - e1, 133);

    // 5: reset 50 cycles into a transfer
    applyStimulus(7'b0000010, 2'b00, 2'b01, 1'b1);
    repeat (68) @(negedge clock);
    checkOutput("t5_busy_before", {31'd0, busy}, 1);
    xc = xferCount;
    reset = 1'b1;
    #1;
    checkOutput("t5_outputs_low", {28'd0, SPI_data, SPI_clock, SPI_strobe, busy}, 32'd0);
    repeat (2) @(negedge clock);
    reset    = 1'b0;
    relCycle = cycle;
    waitTransfer(xc + 1, 300);
    checkOutput("t5_start", busyRise - relCycle, 2);
    checkOutput("t5_word", lastWord, 16'hA002);
    checkOutput("t5_edges", lastEdges, 16);

    // 6: antenna change during SHIFT waits for the next transfer
    applyStimulus(7'b0000010, 2'b00, 2'b01, 1'b0);
    c1 = chgCycle;
    repeat (30) @(negedge clock);
    applyStimulus(7'b0000010, 2'b00, 2'b10, 1'b0);
    waitTransfer(xc + 2, 300);
    checkOutput("t6a_word", lastWord, 16'h2002);
    checkOutput("t6a_end", xferEnd - c1, 134);
    e1 = xferEnd;
    waitTransfer(xc + 3, 400);
    checkOutput("t6b_word", lastWord, 16'h4002);
    checkOutput("t6b_gap", xferEnd - e1, 149);
    checkOutput("t6b_edges", lastEdges, 16);

    $display("test done: total=%0d bad=%0d", checks, bad);
    $finish;
  end

endmodule
